irq_priority_encoder8: RTL and testbench

- 8-to-3 registered priority encoder with request capture; the encode-side counterpart of the team's 3-to-8 one-hot decoder.
- Captures rising edges on 8 request lines into pending bits.
- Presents the index of the highest pending line on a valid/ready handshake, and clears that bit when the index is accepted.
- Sits between raw event/interrupt lines and a consumer that takes one binary index at a time.

---
 rtl/irq_priority_encoder8_pkg.sv | 15 +
 rtl/irq_priority_encoder8_if.sv | 12 +
 rtl/irq_priority_encoder8_prio_enc8.sv | 22 ++
 rtl/irq_priority_encoder8.sv | 115 +++++++++++
 tb/tb_irq_priority_encoder8.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_priority_encoder8_pkg.sv
// Shared constants and types for the 8-line registered priority encoder.
package irq_enc_pkg;

    localparam int unsigned N     = 8;
    localparam int unsigned IDX_W = 3;

    typedef logic [N-1:0]     req_vec_t;
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/irq_priority_encoder8_if.sv
// Index handshake between the encoder (master) and its consumer (slave).
interface irq_priority_encoder8_if;
    import irq_enc_pkg::*;

    idx_t code_o;
    logic valid_o;
    logic ready_i;

    modport master (output code_o, output valid_o, input ready_i);
    modport slave  (input code_o, input valid_o, output ready_i);

endinterface

// File: rtl/irq_priority_encoder8_prio_enc8.sv
// Combinational 8-to-3 priority encoder: bit 7 has the highest priority.
module prio_enc8
    import irq_enc_pkg::*;
(
    input  req_vec_t vec_i,
    output idx_t     idx_o,
    output logic     any_o
);

    // Ascending scan so the highest set bit is the last to assign the index.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_priority_encoder8.sv
// Registered 8-to-3 priority encoder with rising-edge request capture,
// valid/ready index handshake and sticky overflow flag.
// Optional macro IRQ_PRIORITY_ENCODER8_MASK_EN adds mask_i, which excludes
// lines from selection without stopping capture or overflow detection.
module irq_priority_encoder8
    import irq_enc_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  req_vec_t                       req_i,
`ifdef IRQ_PRIORITY_ENCODER8_MASK_EN
    input  req_vec_t                       mask_i,
`endif
    input  logic                           ovf_clr_i,
    output req_vec_t                       pending_o,
    output logic                           ovf_o,
    irq_priority_encoder8_if.master        enc_if
);

    state_t   state_q, state_d;
    req_vec_t req_q;
    req_vec_t pending_q, pending_d;
    idx_t     code_q, code_d;
    logic     valid_q, valid_d;
    logic     ovf_q, ovf_d;

    req_vec_t rise;
    req_vec_t clr_vec;
    req_vec_t sel_vec;
    logic     accept;
    idx_t     sel_idx;
    logic     sel_any;

`ifdef IRQ_PRIORITY_ENCODER8_MASK_EN
    assign sel_vec = pending_q & ~mask_i;
`else
    assign sel_vec = pending_q;
`endif

    prio_enc8 u_prio_enc8 (
        .vec_i (sel_vec),
        .idx_o (sel_idx),
        .any_o (sel_any)
    );

    assign rise   = req_i & ~req_q;
    assign accept = (state_q == PRESENT) && valid_q && enc_if.ready_i;

    // Pending update: a new edge on the accepted line re-sets it (set wins);
    // an edge on a still-pending line that is not being cleared is an overflow.
    always_comb begin
        clr_vec = '0;
        if (accept) begin
            clr_vec[code_q] = 1'b1;
        end
        pending_d = (pending_q & ~clr_vec) | rise;
        ovf_d     = ovf_q;
        if (|(rise & pending_q & ~clr_vec)) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    // Handshake FSM: pick the highest selectable line in IDLE, hold it in PRESENT.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (sel_any) begin
                    code_d  = sel_idx;
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (accept) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_q     <= '0;
            pending_q <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_i;
            pending_q <= pending_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign enc_if.code_o  = code_q;
    assign enc_if.valid_o = valid_q;
    assign pending_o      = pending_q;
    assign ovf_o          = ovf_q;

endmodule

// File: tb/tb_irq_priority_encoder8.sv
// Self-checking bench for irq_priority_encoder8: directed scenarios followed
// by random traffic, all compared against a bit-level behavioural model.
module tb_irq_priority_encoder8;
    import irq_enc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       ovf_clr;
    logic [7:0] pending;
    logic       ovf;
`ifdef IRQ_PRIORITY_ENCODER8_MASK_EN
    logic [7:0] mask;
`endif

    irq_priority_encoder8_if bus ();

    irq_priority_encoder8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req),
`ifdef IRQ_PRIORITY_ENCODER8_MASK_EN
        .mask_i    (mask),
`endif
        .ovf_clr_i (ovf_clr),
        .pending_o (pending),
        .ovf_o     (ovf),
        .enc_if    (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit [7:0] m_pend;
    bit [7:0] m_prev;
    bit       m_valid;
    int       m_code;
    bit       m_ovf;
    int       grants[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int highest(input bit [7:0] v);
        for (int k = 7; k >= 0; k--) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pend  = '0;
        m_prev  = '0;
        m_valid = 1'b0;
        m_code  = 0;
        m_ovf   = 1'b0;
    endtask

    // One rising edge of behaviour, computed from the pre-edge inputs.
    task automatic model_update();
        bit [7:0] sel;
        bit [7:0] new_pend;
        bit       acc;
        bit       ovf_new;
        bit       r;
        bit       cleared;
        sel = m_pend;
`ifdef IRQ_PRIORITY_ENCODER8_MASK_EN
        sel = m_pend & ~mask;
`endif
        acc     = m_valid && (bus.ready_i === 1'b1);
        ovf_new = 1'b0;
        for (int k = 0; k < 8; k++) begin
            r       = req[k] && !m_prev[k];
            cleared = acc && (k == m_code);
            if (r && m_pend[k] && !cleared) ovf_new = 1'b1;
            new_pend[k] = (m_pend[k] && !cleared) || r;
        end
        if (acc) grants.push_back(m_code);
        if (!m_valid) begin
            if (sel != 0) begin
                m_code  = highest(sel);
                m_valid = 1'b1;
            end
        end else if (acc) begin
            m_valid = 1'b0;
        end
        if (ovf_new)      m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        m_pend = new_pend;
        m_prev = req;
    endtask

    task automatic compare_all();
        chk("valid",   32'(bus.valid_o), 32'(m_valid));
        chk("code",    32'(bus.code_o),  32'(m_code));
        chk("pending", 32'(pending),     32'(m_pend));
        chk("ovf",     32'(ovf),         32'(m_ovf));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_update();
        #1;
        compare_all();
    endtask

    initial begin
        rst_n         = 1'b0;
        req           = '0;
        ovf_clr       = 1'b0;
        bus.ready_i   = 1'b0;
`ifdef IRQ_PRIORITY_ENCODER8_MASK_EN
        mask          = '0;
`endif
        model_reset();
        #12;
        chk("rst_valid",   32'(bus.valid_o), 32'd0);
        chk("rst_pending", 32'(pending),     32'd0);
        chk("rst_ovf",     32'(ovf),         32'd0);
        chk("rst_code",    32'(bus.code_o),  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        step();

        // Single request: valid at t+2 with code 4, pending drains after accept
        bus.ready_i = 1'b1;
        req = 8'h10;
        step();
        chk("single_pend", 32'(pending), 32'h10);
        chk("single_nv",   32'(bus.valid_o), 32'd0);
        req = 8'h00;
        step();
        chk("single_valid", 32'(bus.valid_o), 32'd1);
        chk("single_code",  32'(bus.code_o),  32'd4);
        step();
        chk("single_drain", 32'(pending), 32'h00);
        step();

        // Priority: 0x85 -> 7, 2, 0
        grants.delete();
        req = 8'h85;
        step();
        req = 8'h00;
        repeat (8) step();
        chk("prio_n", 32'(grants.size()), 32'd3);
        if (grants.size() == 3) begin
            chk("prio_0", 32'(grants[0]), 32'd7);
            chk("prio_1", 32'(grants[1]), 32'd2);
            chk("prio_2", 32'(grants[2]), 32'd0);
        end

        // Backpressure: code 1 held while a higher line arrives
        bus.ready_i = 1'b0;
        req = 8'h02;
        step();
        req = 8'h00;
        step();
        step();
        req = 8'h40;
        step();
        req = 8'h00;
        step();
        step();
        chk("bp_hold_code",  32'(bus.code_o),  32'd1);
        chk("bp_hold_valid", 32'(bus.valid_o), 32'd1);
        bus.ready_i = 1'b1;
        step();
        step();
        chk("bp_next_code", 32'(bus.code_o), 32'd6);
        step();
        step();

        // Overflow on a still-pending line, then clear
        bus.ready_i = 1'b0;
        req = 8'h08;
        step();
        req = 8'h00;
        step();
        req = 8'h08;
        step();
        chk("ovf_set", 32'(ovf), 32'd1);
        req = 8'h00;
        ovf_clr = 1'b1;
        step();
        chk("ovf_clr", 32'(ovf), 32'd0);
        ovf_clr = 1'b0;
        // Edge on line 3 in the same cycle code 3 is accepted: set wins
        req = 8'h08;
        bus.ready_i = 1'b1;
        step();
        chk("coll_pend", 32'(pending), 32'h08);
        chk("coll_ovf",  32'(ovf),     32'd0);
        req = 8'h00;
        bus.ready_i = 1'b0;
        step();
        chk("coll_re_code",  32'(bus.code_o),  32'd3);
        chk("coll_re_valid", 32'(bus.valid_o), 32'd1);
        bus.ready_i = 1'b1;
        step();
        step();

        // Held-high line does not re-request
        req = 8'h01;
        repeat (6) step();
        chk("held_pend", 32'(pending), 32'h00);
        req = 8'h00;
        step();

`ifdef IRQ_PRIORITY_ENCODER8_MASK_EN
        // Mask: 0x81 pending, line 7 masked -> 0 first, then 7
        bus.ready_i = 1'b0;
        mask = 8'h80;
        req = 8'h81;
        step();
        req = 8'h00;
        step();
        chk("mask_code", 32'(bus.code_o), 32'd0);
        mask = 8'h00;
        bus.ready_i = 1'b1;
        step();
        bus.ready_i = 1'b0;
        step();
        chk("mask_next", 32'(bus.code_o), 32'd7);
        bus.ready_i = 1'b1;
        step();
        step();
`endif

        // Async reset while presenting
        bus.ready_i = 1'b0;
        req = 8'h20;
        step();
        req = 8'h00;
        step();
        chk("arst_pre_valid", 32'(bus.valid_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_valid",   32'(bus.valid_o), 32'd0);
        chk("arst_pending", 32'(pending),     32'd0);
        chk("arst_ovf",     32'(ovf),         32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.ready_i = 1'b1;
        repeat (4) step();
        chk("arst_quiet", 32'(bus.valid_o), 32'd0);

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            req         = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            bus.ready_i = ($urandom_range(0, 3) != 0);
            ovf_clr     = ($urandom_range(0, 7) == 0);
`ifdef IRQ_PRIORITY_ENCODER8_MASK_EN
            if ($urandom_range(0, 15) == 0) mask = 8'($urandom_range(0, 255));
`endif
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
